rf_scoreboard: RTL and testbench

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

---
 rtl/rf_scoreboard_if.sv | 37 +++
 rtl/rf_scoreboard.sv | 89 ++++++++
 tb/tb_rf_scoreboard.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rf_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard_if
//  Description : Bus bundle for the register file with scoreboard: register
//                selects, write/reserve controls, read data and busy flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_scoreboard_if #(
    parameter int WIDTH = 16,
    parameter int SELW  = 3
);
    logic [SELW-1:0]  read1regsel;
    logic [SELW-1:0]  read2regsel;
    logic [SELW-1:0]  writeregsel;
    logic [WIDTH-1:0] writedata;
    logic             write;
    logic             reserve;
    logic [SELW-1:0]  reserveregsel;
    logic [WIDTH-1:0] read1data;
    logic [WIDTH-1:0] read2data;
    logic             read1busy;
    logic             read2busy;
    logic             err;

    modport master (
        output read1regsel, read2regsel, writeregsel, writedata, write,
               reserve, reserveregsel,
        input  read1data, read2data, read1busy, read2busy, err
    );

    modport slave (
        input  read1regsel, read2regsel, writeregsel, writedata, write,
               reserve, reserveregsel,
        output read1data, read2data, read1busy, read2busy, err
    );
endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : NREG x WIDTH register file with two combinational read ports,
//                one write port and a per-register busy (pending producer)
//                scoreboard. Out-of-range selects raise err and are ignored.
//                Optional macro RF_BYPASS_EN forwards the current write to the
//                read ports in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int SELW  = 3
) (
    input  wire              clk,
    input  wire              rst,
    rf_scoreboard_if.slave   bus
);
    // One extra bit so NREG itself is representable even when NREG == 2^SELW
    localparam logic [SELW:0] c_NREG = (SELW+1)'(NREG);

    logic [WIDTH-1:0] r_mem [NREG];
    logic [NREG-1:0]  r_busy;

    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_rd1_ok;
    logic w_rd2_ok;

    assign w_wr_ok  = ({1'b0, bus.writeregsel}   < c_NREG);
    assign w_rsv_ok = ({1'b0, bus.reserveregsel} < c_NREG);
    assign w_rd1_ok = ({1'b0, bus.read1regsel}   < c_NREG);
    assign w_rd2_ok = ({1'b0, bus.read2regsel}   < c_NREG);

    assign bus.err = (bus.write & ~w_wr_ok) | (bus.reserve & ~w_rsv_ok)
                   | ~w_rd1_ok | ~w_rd2_ok;

    // Storage and scoreboard update; a reserve is applied after the write so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (bus.write && w_wr_ok && bus.writeregsel == SELW'(i)) begin
                    r_mem[i]  <= bus.writedata;
                    r_busy[i] <= 1'b0;
                end
                if (bus.reserve && w_rsv_ok && bus.reserveregsel == SELW'(i)) begin
                    r_busy[i] <= 1'b1;
                end
            end
        end
    end

    // Combinational read ports; outputs are held at zero while reset is asserted
    always_comb begin
        bus.read1data = '0;
        bus.read1busy = 1'b0;
        bus.read2data = '0;
        bus.read2busy = 1'b0;
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                if (bus.read1regsel == SELW'(i)) begin
                    bus.read1data = r_mem[i];
                    bus.read1busy = r_busy[i];
                end
                if (bus.read2regsel == SELW'(i)) begin
                    bus.read2data = r_mem[i];
                    bus.read2busy = r_busy[i];
                end
            end
`ifdef RF_BYPASS_EN
            if (bus.write && w_wr_ok && w_rd1_ok && bus.read1regsel == bus.writeregsel) begin
                bus.read1data = bus.writedata;
                bus.read1busy = bus.reserve && w_rsv_ok && (bus.reserveregsel == bus.writeregsel);
            end
            if (bus.write && w_wr_ok && w_rd2_ok && bus.read2regsel == bus.writeregsel) begin
                bus.read2data = bus.writedata;
                bus.read2busy = bus.reserve && w_rsv_ok && (bus.reserveregsel == bus.writeregsel);
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_scoreboard
//  Description : Directed self-checking bench for rf_scoreboard (NREG=6,
//                SELW=3) using an expected-value queue fed by a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_scoreboard;
    localparam int NR = 6;

    typedef struct {
        string       tag;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b1;
        logic        b2;
        logic        e;
    } exp_t;

    logic clk = 1'b1;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    exp_t        q[$];
    logic [15:0] m_data [NR];
    logic        m_busy [NR];

    rf_scoreboard_if #(.WIDTH(16), .SELW(3)) bus ();

    rf_scoreboard #(.WIDTH(16), .NREG(NR), .SELW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the model's view of the read ports,
    // compare mid-cycle, then advance the model on the clock edge.
    task automatic step(input string tag, input int s1, input int s2, input logic r,
                        input logic w, input int ws, input logic [15:0] wd,
                        input logic rv, input int rs);
        exp_t x, y;
        rst               = r;
        bus.read1regsel   = 3'(s1);
        bus.read2regsel   = 3'(s2);
        bus.write         = w;
        bus.writeregsel   = 3'(ws);
        bus.writedata     = wd;
        bus.reserve       = rv;
        bus.reserveregsel = 3'(rs);

        x.tag = tag;
        x.d1  = (!r && s1 < NR) ? m_data[s1] : 16'h0;
        x.b1  = (!r && s1 < NR) ? m_busy[s1] : 1'b0;
        x.d2  = (!r && s2 < NR) ? m_data[s2] : 16'h0;
        x.b2  = (!r && s2 < NR) ? m_busy[s2] : 1'b0;
        x.e   = (w && ws >= NR) || (rv && rs >= NR) || (s1 >= NR) || (s2 >= NR);
`ifdef RF_BYPASS_EN
        if (!r && w && ws < NR && s1 == ws) begin
            x.d1 = wd;
            x.b1 = rv && (rs == ws);
        end
        if (!r && w && ws < NR && s2 == ws) begin
            x.d2 = wd;
            x.b2 = rv && (rs == ws);
        end
`endif
        q.push_back(x);

        @(negedge clk);
        y = q.pop_front();
        chk({y.tag, ".d1"},  bus.read1data, y.d1);
        chk({y.tag, ".d2"},  bus.read2data, y.d2);
        chk({y.tag, ".b1"},  {15'h0, bus.read1busy}, {15'h0, y.b1});
        chk({y.tag, ".b2"},  {15'h0, bus.read2busy}, {15'h0, y.b2});
        chk({y.tag, ".err"}, {15'h0, bus.err},       {15'h0, y.e});

        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NR; i++) begin
                m_data[i] = 16'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (w && ws < NR) begin
                m_data[ws] = wd;
                m_busy[ws] = 1'b0;
            end
            if (rv && rs < NR) m_busy[rs] = 1'b1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_data[i] = 16'h0;
            m_busy[i] = 1'b0;
        end
        // Reset together with a write and reserve that must be ignored
        step("rst0",  0, 1, 1'b1, 1'b1, 1, 16'hFFFF, 1'b1, 1);
        for (int i = 0; i < NR; i++) step("post_rst", i, i, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);

        // Basic write then read on both ports
        step("wr5",     0, 0, 1'b0, 1'b1, 5, 16'hBEEF, 1'b0, 0);
        step("rd5",     5, 5, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);
        step("rd0_4",   0, 4, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);

        // Scoreboard: reserve, write clears, same-edge reserve+write, re-reserve
        step("rsv3",    3, 5, 1'b0, 1'b0, 0, 16'h0,    1'b1, 3);
        step("busy3",   3, 3, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);
        step("wr3",     3, 0, 1'b0, 1'b1, 3, 16'h1234, 1'b0, 0);
        step("clr3",    3, 3, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);
        step("rsvwr3",  4, 4, 1'b0, 1'b1, 3, 16'h5678, 1'b1, 3);
        step("both3",   3, 3, 1'b0, 1'b0, 0, 16'h0,    1'b1, 3);
        step("again3",  3, 5, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);

        // Same-cycle write/read (bypass-dependent), then stored value
        step("byp2",    2, 2, 1'b0, 1'b1, 2, 16'hA5A5, 1'b0, 0);
        step("rd2",     2, 1, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);
        step("byp2rv",  2, 0, 1'b0, 1'b1, 2, 16'h0F0F, 1'b1, 2);
        step("rd2b",    2, 2, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);

        // Out-of-range selects
        step("wr7",     0, 5, 1'b0, 1'b1, 7, 16'h1111, 1'b0, 0);
        step("rd6",     6, 5, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);
        step("rd7",     2, 7, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);
        step("rsv7",    0, 3, 1'b0, 1'b0, 0, 16'h0,    1'b1, 7);
        step("wr6",     0, 1, 1'b0, 1'b1, 6, 16'h2222, 1'b1, 6);
        for (int i = 0; i < NR; i++) step("hold", i, NR - 1 - i, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);

        // Reset mid-sequence beats a simultaneous write and reserve
        step("wr1",     1, 1, 1'b0, 1'b1, 1, 16'h7777, 1'b1, 4);
        step("rst1",    1, 4, 1'b1, 1'b1, 1, 16'hFFFF, 1'b1, 1);
        step("rd1",     1, 5, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);
        step("rd4_3",   4, 3, 1'b0, 1'b0, 0, 16'h0,    1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
